// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its command FIFO.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_BUSY,
    ST_FULL
  } stage_state_t;

  // Divide with a zero divisor is flagged here rather than trusted to the ALU.
  function automatic logic is_div_zero(cmd_t c);
    return (c.opcode == OP_DIV) && (c.b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read data and occupancy count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  cmd_t                   wr_data,
  input  logic                   rd_en,
  output cmd_t                   rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Command queue in front of a combinational ALU plus a registered,
// back-pressurable result stage with zero and divide-by-zero flags.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_opcode,
  output logic              res_zero,
  output logic              res_dz
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  cmd_t              cmd_in;
  cmd_t              fifo_rd_data;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              capture;
  logic              head_dz;
  logic [DATA_W-1:0] res_next;
  stage_state_t      state_q;
  stage_state_t      state_d;
  logic [CNT_W-1:0]  cnt_next;
  logic              rv_next;

  assign cmd_in  = {cmd_opcode, cmd_a, cmd_b};
  assign push    = cmd_valid && !fifo_full;
  assign capture = !fifo_empty && (!res_valid || res_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (cmd_in),
    .rd_en   (capture),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Present the FIFO head to the ALU, forced to zero when nothing is queued.
  always_comb begin
    head       = fifo_empty ? '0 : fifo_rd_data;
    alu_opcode = head.opcode;
    alu_a      = head.a;
    alu_b      = head.b;
    head_dz    = is_div_zero(head);
    res_next   = head_dz ? '1 : alu_result;
  end

  // Result register: load on capture, clear valid on a drain with no refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
      res_zero   <= 1'b0;
      res_dz     <= 1'b0;
    end else if (capture) begin
      res_valid  <= 1'b1;
      res_data   <= res_next;
      res_opcode <= head.opcode;
      res_zero   <= (res_next == '0);
      res_dz     <= head_dz;
    end else if (res_valid && res_ready) begin
      res_valid  <= 1'b0;
    end
  end

  // Stage state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // State is derived from the post-edge occupancy and result-valid values.
  always_comb begin
    cnt_next = fifo_count;
    if (push && !capture)      cnt_next = fifo_count + CNT_W'(1);
    else if (!push && capture) cnt_next = fifo_count - CNT_W'(1);
    rv_next = res_valid;
    if (capture)                     rv_next = 1'b1;
    else if (res_valid && res_ready) rv_next = 1'b0;
    if (cnt_next == CNT_W'(DEPTH))         state_d = ST_FULL;
    else if (cnt_next == '0 && !rv_next)   state_d = ST_EMPTY;
    else                                   state_d = ST_BUSY;
  end

  // Accept commands in every state except FULL; no push-through when full.
  always_comb begin
    cmd_ready = (state_q != ST_FULL);
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a behavioural ALU.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_opcode;
  logic       res_zero;
  logic       res_dz;

  int total;
  int bad;

  alu_issue_stage #(.DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode),
    .res_zero   (res_zero),
    .res_dz     (res_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; divide by zero returns 0 so only the stage can produce FF.
  always_comb begin
    case (alu_opcode)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_DIV:  alu_result = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      OP_MUL:  alu_result = 8'(alu_a * alu_b);
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_NOT:  alu_result = ~alu_a;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    total++; if (res_data !== 8'h00) begin bad++; $display("FAIL reset_res_data got=%h want=00", res_data); end
    total++; if ({res_opcode, res_zero, res_dz} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {res_opcode, res_zero, res_dz}); end
    total++; if ({alu_opcode, alu_a, alu_b} !== 19'h0) begin bad++; $display("FAIL reset_alu_head got=%h want=0", {alu_opcode, alu_a, alu_b}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    res_ready = 1'b1;
    drive_cmd(OP_ADD, 8'h12, 8'h34);
    step();
    cmd_valid = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", res_valid); end
    total++; if ({alu_opcode, alu_a, alu_b} !== {OP_ADD, 8'h12, 8'h34}) begin bad++; $display("FAIL single_head got=%h want=%h", {alu_opcode, alu_a, alu_b}, {OP_ADD, 8'h12, 8'h34}); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", res_valid); end
    total++; if (res_data !== 8'h46) begin bad++; $display("FAIL single_data got=%h want=46", res_data); end
    total++; if ({res_opcode, res_zero, res_dz} !== 5'b000_0_0) begin bad++; $display("FAIL single_flags got=%b want=00000", {res_opcode, res_zero, res_dz}); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", res_valid); end
  endtask

  task automatic test_flags;
    logic [2:0] ops [3];
    logic [7:0] as  [3];
    logic [7:0] bs  [3];
    logic [7:0] exp_d [3];
    logic       exp_z [3];
    logic       exp_dz [3];
    ops = '{OP_DIV, OP_XOR, OP_DIV};
    as  = '{8'h40, 8'h5A, 8'h40};
    bs  = '{8'h00, 8'h5A, 8'h04};
    exp_d  = '{8'hFF, 8'h00, 8'h10};
    exp_z  = '{1'b0, 1'b1, 1'b0};
    exp_dz = '{1'b1, 1'b0, 1'b0};
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(ops[i], as[i], bs[i]);
      step();
      cmd_valid = 1'b0;
      step();
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL flags%0d_valid got=%b want=1", i, res_valid); end
      total++; if (res_data !== exp_d[i]) begin bad++; $display("FAIL flags%0d_data got=%h want=%h", i, res_data, exp_d[i]); end
      total++; if (res_zero !== exp_z[i]) begin bad++; $display("FAIL flags%0d_zero got=%b want=%b", i, res_zero, exp_z[i]); end
      total++; if (res_dz !== exp_dz[i]) begin bad++; $display("FAIL flags%0d_dz got=%b want=%b", i, res_dz, exp_dz[i]); end
      total++; if (res_opcode !== ops[i]) begin bad++; $display("FAIL flags%0d_opcode got=%b want=%b", i, res_opcode, ops[i]); end
      step();
    end
  endtask

  task automatic test_backpressure;
    logic [2:0] ops [5];
    logic [7:0] as  [5];
    logic [7:0] bs  [5];
    logic [7:0] exp_d [5];
    logic       accepted;
    int         got;
    ops = '{OP_MUL, OP_SUB, OP_AND, OP_OR, OP_NOT};
    as  = '{8'h0A, 8'h05, 8'hF0, 8'h0F, 8'hA5};
    bs  = '{8'h14, 8'h07, 8'h3C, 8'h30, 8'h00};
    exp_d = '{8'hC8, 8'hFE, 8'h30, 8'h3F, 8'h5A};
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(ops[i], as[i], bs[i]);
      accepted = 1'b0;
      for (int w = 0; w < 10 && !accepted; w++) begin
        accepted = cmd_ready;
        step();
      end
      total++; if (accepted !== 1'b1) begin bad++; $display("FAIL bp_push%0d_timeout got=%b want=1", i, accepted); end
    end
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", cmd_ready); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_held_valid got=%b want=1", res_valid); end
    total++; if (res_data !== 8'hC8) begin bad++; $display("FAIL bp_held_data got=%h want=c8", res_data); end
    repeat (3) step();
    total++; if ({res_valid, res_data, res_opcode} !== {1'b1, 8'hC8, OP_MUL}) begin bad++; $display("FAIL bp_stall_stable got=%h want=%h", {res_valid, res_data, res_opcode}, {1'b1, 8'hC8, OP_MUL}); end
    total++; if (alu_opcode !== OP_SUB) begin bad++; $display("FAIL bp_head_kept got=%b want=%b", alu_opcode, OP_SUB); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%b want=0", cmd_ready); end
    res_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      if (res_valid) begin
        total++; if (res_data !== exp_d[got]) begin bad++; $display("FAIL bp_result%0d got=%h want=%h", got, res_data, exp_d[got]); end
        total++; if (res_opcode !== ops[got]) begin bad++; $display("FAIL bp_opcode%0d got=%b want=%b", got, res_opcode, ops[got]); end
        got++;
      end
      step();
      if (cyc == 0) begin
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b want=1", cmd_ready); end
      end
    end
    total++; if (got !== 5) begin bad++; $display("FAIL bp_result_count got=%0d want=5", got); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", res_valid); end
  endtask

  task automatic test_back_to_back;
    localparam int N = 8;
    res_ready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      if (i < N) drive_cmd(OP_ADD, 8'(8'h10 + i), 8'h01);
      else       cmd_valid = 1'b0;
      step();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_ready got=%b want=1", i, cmd_ready); end
      total++; if (u_dut.fifo_count > 1) begin bad++; $display("FAIL b2b%0d_count got=%0d want<=1", i, u_dut.fifo_count); end
      if (i == 0) begin
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL b2b_first_valid got=%b want=0", res_valid); end
      end else begin
        total++; if ({res_valid, res_data} !== {1'b1, 8'(8'h11 + i - 1)}) begin bad++; $display("FAIL b2b%0d_result got=%h want=%h", i, {res_valid, res_data}, {1'b1, 8'(8'h11 + i - 1)}); end
      end
    end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail_valid got=%b want=0", res_valid); end
  endtask

  task automatic test_wrap;
    localparam int N = 3 * DEPTH;
    int   sent;
    int   got;
    logic accepted;
    logic pushed_last;
    sent = 0;
    got = 0;
    pushed_last = 1'b0;
    res_ready = 1'b0;
    for (int cyc = 0; cyc < 80 && got < N; cyc++) begin
      if (!res_ready && sent == DEPTH) begin
        total++; if (u_dut.fifo_count !== 3'(DEPTH - 1)) begin bad++; $display("FAIL wrap_prefill_count got=%0d want=%0d", u_dut.fifo_count, DEPTH - 1); end
        res_ready = 1'b1;
      end
      if (res_ready && pushed_last) begin
        total++; if ({u_dut.fifo_count, cmd_ready} !== {3'(DEPTH - 1), 1'b1}) begin bad++; $display("FAIL wrap_steady sent=%0d count=%0d ready=%b want count=%0d ready=1", sent, u_dut.fifo_count, cmd_ready, DEPTH - 1); end
      end
      if (res_valid && res_ready) begin
        total++; if (res_data !== 8'(8'h20 + got)) begin bad++; $display("FAIL wrap_result%0d got=%h want=%h", got, res_data, 8'(8'h20 + got)); end
        got++;
      end
      if (sent < N) begin
        drive_cmd(OP_ADD, 8'(sent), 8'h20);
        accepted = cmd_ready;
      end else begin
        cmd_valid = 1'b0;
        accepted = 1'b0;
      end
      step();
      if (accepted) sent++;
      pushed_last = accepted;
    end
    cmd_valid = 1'b0;
    total++; if (got !== N) begin bad++; $display("FAIL wrap_result_count got=%0d want=%0d", got, N); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL wrap_tail_valid got=%b want=0", res_valid); end
  endtask

  task automatic test_reset_mid;
    logic accepted;
    logic seen;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(OP_XOR, 8'(8'h70 + i), 8'h00);
      accepted = 1'b0;
      for (int w = 0; w < 10 && !accepted; w++) begin
        accepted = cmd_ready;
        step();
      end
      total++; if (accepted !== 1'b1) begin bad++; $display("FAIL rstmid_push%0d_timeout got=%b want=1", i, accepted); end
    end
    cmd_valid = 1'b0;
    total++; if ({res_valid, u_dut.fifo_count} !== {1'b1, 3'd3}) begin bad++; $display("FAIL rstmid_loaded got=%h want=%h", {res_valid, u_dut.fifo_count}, {1'b1, 3'd3}); end
    rst_n = 1'b0;
    step();
    total++; if ({res_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_after_reset got=%b want=01", {res_valid, cmd_ready}); end
    total++; if ({alu_opcode, alu_a, alu_b, res_data} !== 27'h0) begin bad++; $display("FAIL rstmid_cleared got=%h want=0", {alu_opcode, alu_a, alu_b, res_data}); end
    rst_n = 1'b1;
    res_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_ghost_result got=%b want=0", seen); end
    drive_cmd(OP_ADD, 8'h01, 8'h01);
    step();
    cmd_valid = 1'b0;
    step();
    total++; if ({res_valid, res_data} !== {1'b1, 8'h02}) begin bad++; $display("FAIL rstmid_fresh got=%h want=%h", {res_valid, res_data}, {1'b1, 8'h02}); end
    step();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    res_ready  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
